// File: rtl/arp_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : arp_requester                                                |
// | Description : ARP initiator. On start it transmits a broadcast who-has     |
// |               request for target_ip_i, then watches the RX stream for the  |
// |               matching reply and returns the sender MAC. Retransmits after |
// |               TIMEOUT_CYCLES of silence, up to MAX_RETRIES times.          |
// | Ports       : clk_i/rst            - clock, synchronous active-high reset  |
// |               ether_hw_addr_i/     - own MAC / IPv4 (static while busy)    |
// |               ether_ipv4_addr_i                                            |
// |               start_i/target_ip_i  - resolve request                       |
// |               busy_o/done_o/       - status; done_o is a one-cycle pulse   |
// |               success_o/resolved_mac_o                                     |
// |               mac_rx_valid_i/data  - RX byte stream (frame from dest MAC)  |
// |               mac_tx_valid_o/data/ack - TX byte stream toward the TX mux   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module arp_requester #(
  parameter int TIMEOUT_CYCLES = 125000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic [47:0] ether_hw_addr_i,
  input  logic [31:0] ether_ipv4_addr_i,
  input  logic        start_i,
  input  logic [31:0] target_ip_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        success_o,
  output logic [47:0] resolved_mac_o,
  input  logic        mac_rx_valid_i,
  input  logic [7:0]  mac_rx_data_i,
  output logic        mac_tx_valid_o,
  output logic [7:0]  mac_tx_data_o,
  input  logic        mac_tx_ack_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ATT_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [5:0]       FRAME_LAST = 6'd41;
  localparam logic [5:0]       RX_SAT     = 6'd42;
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ATT_W-1:0] ATT_MAX    = ATT_W'(MAX_RETRIES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TX   = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Byte n (0 = most significant) of a MAC / IPv4 address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] n);
    logic [47:0] s;
    s = mac << {n, 3'b000};
    return s[47:40];
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] n);
    logic [31:0] s;
    s = ip << {n, 3'b000};
    return s[31:24];
  endfunction

  // Request frame layout: broadcast Ethernet header + ARP who-has.
  function automatic logic [7:0] tx_byte(input logic [5:0]  idx,
                                         input logic [47:0] mac,
                                         input logic [31:0] ip,
                                         input logic [31:0] tgt);
    logic [7:0] b;
    b = 8'h00;
    if (idx <= 6'd5)                      b = 8'hFF;
    else if (idx <= 6'd11)                b = mac_byte(mac, 3'(idx - 6'd6));
    else if (idx >= 6'd22 && idx <= 6'd27) b = mac_byte(mac, 3'(idx - 6'd22));
    else if (idx >= 6'd28 && idx <= 6'd31) b = ip_byte(ip, 2'(idx - 6'd28));
    else if (idx >= 6'd38 && idx <= 6'd41) b = ip_byte(tgt, 2'(idx - 6'd38));
    else begin
      case (idx)
        6'd12, 6'd16: b = 8'h08;
        6'd13, 6'd18: b = 8'h06;
        6'd15, 6'd21: b = 8'h01;
        6'd19:        b = 8'h04;
        default:      b = 8'h00;
      endcase
    end
    return b;
  endfunction

  state_t           state, state_next;
  logic [31:0]      target_ip;
  logic [5:0]       tx_idx;
  logic [TMO_W-1:0] tmo_cnt;
  logic [ATT_W-1:0] attempts;

  logic [5:0]       rx_idx;
  logic             rx_ok;      // all checked bytes of the current frame so far matched
  logic [47:0]      rx_sha;
  logic             rx_chk;
  logic [7:0]       rx_exp;
  logic             byte_ok;
  logic             rx_match;

  logic tx_accept, tx_last, tmo_hit, retry_left;

  assign tx_accept  = mac_tx_valid_o && mac_tx_ack_i;
  assign tx_last    = tx_accept && (tx_idx == FRAME_LAST);
  // The wait window is exactly TIMEOUT_CYCLES cycles: this is its final cycle.
  assign tmo_hit    = (tmo_cnt == TMO_LAST);
  assign retry_left = (attempts < ATT_MAX);

  // ------------------------------------------------------------------
  // RX reply parser (runs regardless of FSM state)
  // ------------------------------------------------------------------
  always_comb begin
    rx_chk = 1'b0;
    rx_exp = 8'h00;
    if (rx_idx >= 6'd28 && rx_idx <= 6'd31) begin
      rx_chk = 1'b1;
      rx_exp = ip_byte(target_ip, 2'(rx_idx - 6'd28));
    end else if (rx_idx >= 6'd32 && rx_idx <= 6'd37) begin
      rx_chk = 1'b1;
      rx_exp = mac_byte(ether_hw_addr_i, 3'(rx_idx - 6'd32));
    end else if (rx_idx >= 6'd38 && rx_idx <= 6'd41) begin
      rx_chk = 1'b1;
      rx_exp = ip_byte(ether_ipv4_addr_i, 2'(rx_idx - 6'd38));
    end else begin
      case (rx_idx)
        6'd12:   begin rx_chk = 1'b1; rx_exp = 8'h08; end
        6'd13:   begin rx_chk = 1'b1; rx_exp = 8'h06; end
        6'd20:   begin rx_chk = 1'b1; rx_exp = 8'h00; end
        6'd21:   begin rx_chk = 1'b1; rx_exp = 8'h02; end
        default: begin rx_chk = 1'b0; rx_exp = 8'h00; end
      endcase
    end
  end

  assign byte_ok  = !rx_chk || (mac_rx_data_i == rx_exp);
  // Decided combinationally on byte 41 so done_o can be registered next cycle.
  assign rx_match = mac_rx_valid_i && (rx_idx == FRAME_LAST) && rx_ok && byte_ok;

  always_ff @(posedge clk_i) begin
    if (rst) begin
      rx_idx <= '0;
      rx_ok  <= 1'b0;
      rx_sha <= '0;
    end else if (!mac_rx_valid_i) begin
      rx_idx <= '0;
    end else if (rx_idx != RX_SAT) begin
      rx_idx <= rx_idx + 6'd1;
      rx_ok  <= ((rx_idx == 6'd0) ? 1'b1 : rx_ok) & byte_ok;
      if (rx_idx >= 6'd22 && rx_idx <= 6'd27) begin
        rx_sha <= {rx_sha[39:0], mac_rx_data_i};
      end
    end
  end

  // ------------------------------------------------------------------
  // Control FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_i) state_next = TX;
      TX:   if (tx_last) state_next = WAIT;
      WAIT: begin
        if (rx_match)     state_next = IDLE;
        else if (tmo_hit) state_next = retry_left ? TX : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      success_o      <= 1'b0;
      resolved_mac_o <= '0;
      mac_tx_valid_o <= 1'b0;
      mac_tx_data_o  <= '0;
      target_ip      <= '0;
      tx_idx         <= '0;
      tmo_cnt        <= '0;
      attempts       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            target_ip <= target_ip_i;
            attempts  <= '0;
            busy_o    <= 1'b1;
          end
        end
        TX: begin
          // Valid low on entry: launch byte 0 (first attempt or retry alike).
          if (!mac_tx_valid_o) begin
            mac_tx_valid_o <= 1'b1;
            tx_idx         <= '0;
            mac_tx_data_o  <= tx_byte(6'd0, ether_hw_addr_i, ether_ipv4_addr_i, target_ip);
          end else if (tx_accept) begin
            if (tx_idx == FRAME_LAST) begin
              mac_tx_valid_o <= 1'b0;
              mac_tx_data_o  <= '0;
              tmo_cnt        <= '0;
            end else begin
              tx_idx        <= tx_idx + 6'd1;
              mac_tx_data_o <= tx_byte(tx_idx + 6'd1, ether_hw_addr_i,
                                       ether_ipv4_addr_i, target_ip);
            end
          end
        end
        WAIT: begin
          // A reply completing on the timeout cycle still counts.
          if (rx_match) begin
            done_o         <= 1'b1;
            success_o      <= 1'b1;
            resolved_mac_o <= rx_sha;
            busy_o         <= 1'b0;
          end else if (tmo_hit) begin
            tmo_cnt <= '0;
            if (retry_left) begin
              attempts <= attempts + ATT_W'(1);
            end else begin
              done_o    <= 1'b1;
              success_o <= 1'b0;
              busy_o    <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arp_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_arp_requester                                             |
// | Description : Directed self-checking bench for arp_requester. Main DUT     |
// |               (long timeout) covers resolve, backpressure, filtering,      |
// |               truncation, start-while-busy and reset mid-TX; a second      |
// |               instance (TIMEOUT 100, 2 retries) covers retry/failure.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_arp_requester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic [47:0] hw;
  logic [31:0] ip;
  logic [31:0] tgt;

  logic        start, busy, done, success, rxv, txv, ack;
  logic [47:0] rmac;
  logic [7:0]  rxd, txd;

  logic        start_r, busy_r, done_r, success_r, rxv_r, txv_r, ack_r;
  logic [47:0] rmac_r;
  logic [7:0]  rxd_r, txd_r;

  arp_requester #(.TIMEOUT_CYCLES(1000), .MAX_RETRIES(3)) dut (
    .clk_i(clk), .rst(rst),
    .ether_hw_addr_i(hw), .ether_ipv4_addr_i(ip),
    .start_i(start), .target_ip_i(tgt),
    .busy_o(busy), .done_o(done), .success_o(success), .resolved_mac_o(rmac),
    .mac_rx_valid_i(rxv), .mac_rx_data_i(rxd),
    .mac_tx_valid_o(txv), .mac_tx_data_o(txd), .mac_tx_ack_i(ack)
  );

  arp_requester #(.TIMEOUT_CYCLES(100), .MAX_RETRIES(2)) dut_r (
    .clk_i(clk), .rst(rst),
    .ether_hw_addr_i(hw), .ether_ipv4_addr_i(ip),
    .start_i(start_r), .target_ip_i(tgt),
    .busy_o(busy_r), .done_o(done_r), .success_o(success_r), .resolved_mac_o(rmac_r),
    .mac_rx_valid_i(rxv_r), .mac_rx_data_i(rxd_r),
    .mac_tx_valid_o(txv_r), .mac_tx_data_o(txd_r), .mac_tx_ack_i(ack_r)
  );

  // Request for MAC 02:00:00:00:00:01, IP C0A8010A, target C0A80114.
  logic [7:0] exp_req [0:41] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h01,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'hC0, 8'hA8, 8'h01, 8'h0A,
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
    8'hC0, 8'hA8, 8'h01, 8'h14
  };

  // Reply from 02:11:22:33:44:55 / C0A80114 to us.
  logic [7:0] rep_ok [0:41] = '{
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
    8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
    8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
    8'hC0, 8'hA8, 8'h01, 8'h14,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'hC0, 8'hA8, 8'h01, 8'h0A
  };

  logic [7:0] rx_frame [0:41];
  logic [7:0] cap      [0:41];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] t);
    start = 1'b1;
    tgt   = t;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Accepts one main-DUT frame; toggle=1 gives ack 1,0,1,0... from byte 0.
  task automatic collect_frame(input bit toggle, input int exp_cyc, input string tag);
    int guard, k, nb, gaps, unstable;
    logic [7:0] held;
    bit pend;
    guard = 0; k = 0; nb = 0; gaps = 0; unstable = 0; pend = 0; held = 8'h00;
    while (!txv && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_valid_rise"}, txv, 1);
    if (txv) begin
      while (nb < 42 && k < 200) begin
        if (!txv) gaps++;
        ack = toggle ? ((k % 2) == 0) : 1'b1;
        if (pend && txd !== held) unstable++;
        if (txv && ack) begin
          cap[nb] = txd;
          nb++;
          pend = 0;
        end else if (txv) begin
          held = txd;
          pend = 1;
        end
        k++;
        @(negedge clk);
      end
      ack = 1'b1;
      check({tag, "_cycles"}, k, exp_cyc);
      check({tag, "_gaps"}, gaps, 0);
      check({tag, "_unstable"}, unstable, 0);
      check({tag, "_valid_drop"}, txv, 0);
      for (int i = 0; i < 42; i++) check($sformatf("%s_b%0d", tag, i), cap[i], exp_req[i]);
    end
  endtask

  // One idle cycle, then the frame; returns at the negedge after the last byte.
  task automatic send_rx(input int len);
    rxv = 1'b0;
    @(negedge clk);
    for (int i = 0; i < len; i++) begin
      rxv = 1'b1;
      rxd = rx_frame[i];
      @(negedge clk);
    end
    rxv = 1'b0;
    rxd = 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, first, last, prev_last, nb, bad;
    rst = 1'b1; hw = 48'h020000000001; ip = 32'hC0A8010A; tgt = '0;
    start = 1'b0; rxv = 1'b0; rxd = '0; ack = 1'b1;
    start_r = 1'b0; rxv_r = 1'b0; rxd_r = '0; ack_r = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_success", success, 0);
    check("rst_mac", rmac, 0);
    check("rst_txv", txv, 0);
    check("rst_txd", txd, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic resolve
    do_start(32'hC0A80114);
    check("basic_busy", busy, 1);
    collect_frame(0, 42, "basic");
    check("basic_busy_wait", busy, 1);
    rx_frame = rep_ok;
    send_rx(42);
    check("basic_done", done, 1);
    check("basic_success", success, 1);
    check("basic_mac", rmac, 48'h021122334455);
    check("basic_busy_end", busy, 0);
    @(negedge clk);
    check("basic_done_pulse", done, 0);

    // Backpressure
    do_start(32'hC0A80114);
    collect_frame(1, 83, "bp");
    rx_frame = rep_ok;
    send_rx(42);
    check("bp_done", done, 1);
    check("bp_success", success, 1);

    // Filtering: OPER request, wrong SPA, wrong THA, IPv4 ethertype
    do_start(32'hC0A80114);
    collect_frame(0, 42, "flt");
    for (int v = 0; v < 4; v++) begin
      rx_frame = rep_ok;
      case (v)
        0: rx_frame[21] = 8'h01;
        1: rx_frame[31] = 8'h15;
        2: rx_frame[37] = 8'h02;
        default: rx_frame[13] = 8'h00;
      endcase
      send_rx(42);
      check($sformatf("flt%0d_done", v), done, 0);
      check($sformatf("flt%0d_busy", v), busy, 1);
    end
    check("flt_mac_held", rmac, 48'h021122334455);
    rx_frame = rep_ok;
    rx_frame[27] = 8'h66;
    send_rx(42);
    check("flt_done", done, 1);
    check("flt_success", success, 1);
    check("flt_mac", rmac, 48'h021122334466);

    // Truncated reply (bytes 0..30 only), then a full one
    do_start(32'hC0A80114);
    collect_frame(0, 42, "tr");
    rx_frame = rep_ok;
    send_rx(31);
    check("tr_short_done", done, 0);
    send_rx(42);
    check("tr_done", done, 1);
    check("tr_mac", rmac, 48'h021122334455);

    // Start while busy is ignored; latched target stays C0A80114
    do_start(32'hC0A80114);
    collect_frame(0, 42, "sb");
    do_start(32'hC0A80115);
    @(negedge clk);
    check("sb_busy", busy, 1);
    check("sb_no_tx", txv, 0);
    rx_frame = rep_ok;
    rx_frame[31] = 8'h15;
    send_rx(42);
    check("sb_new_tgt_done", done, 0);
    rx_frame = rep_ok;
    send_rx(42);
    check("sb_done", done, 1);
    check("sb_success", success, 1);

    // Reset while byte 10 is on the bus
    do_start(32'hC0A80114);
    guard = 0;
    while (!txv && guard < 20) begin @(negedge clk); guard++; end
    repeat (10) @(negedge clk);
    check("rmid_byte10", txd, exp_req[10]);
    rst = 1'b1;
    @(negedge clk);
    check("rmid_txv", txv, 0);
    check("rmid_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    do_start(32'hC0A80114);
    collect_frame(0, 42, "rmid2");

    // Retry instance: three frames, then failure. The FSM re-enters TX
    // 101 cycles after the last accept; valid follows one cycle later.
    start_r = 1'b1;
    tgt = 32'hC0A80114;
    @(negedge clk);
    start_r = 1'b0;
    prev_last = 0;
    for (int f = 0; f < 3; f++) begin
      guard = 0;
      while (!txv_r && guard < 300) begin @(negedge clk); guard++; end
      first = cyc;
      if (f > 0) check($sformatf("rty%0d_gap", f), first - prev_last, 102);
      nb = 0; bad = 0; last = first;
      while (txv_r && nb < 60) begin
        if (nb < 42 && txd_r !== exp_req[nb]) bad++;
        nb++;
        last = cyc;
        @(negedge clk);
      end
      check($sformatf("rty%0d_len", f), nb, 42);
      check($sformatf("rty%0d_bytes_bad", f), bad, 0);
      check($sformatf("rty%0d_busy", f), busy_r, 1);
      prev_last = last;
    end
    guard = 0;
    while (!done_r && guard < 300) begin @(negedge clk); guard++; end
    check("rty_done", done_r, 1);
    check("rty_done_time", cyc - prev_last, 101);
    check("rty_success", success_r, 0);
    check("rty_mac_held", rmac_r, 0);
    check("rty_busy", busy_r, 0);
    guard = 0;
    for (int i = 0; i < 150; i++) begin
      if (txv_r) guard++;
      @(negedge clk);
    end
    check("rty_no_4th_frame", guard, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
